mem_port_arbiter: RTL

Sequences and shares one single-port word memory (DEPTH x WIDTH) between two requesters.
After reset it runs an init sequence that writes mem[i] = i into every word. It then grants one read or write per cycle using round-robin arbitration.
The full memory image is exported as a flat packed vector, word i at bits [i*WIDTH +: WIDTH], for checking and for downstream consumers.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port word memory.
// Fills mem[i] = i after reset, then serves one read or write per cycle.
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [AW-1:0]          req0_addr,
  input  logic [WIDTH-1:0]       req0_wdata,
  output logic                   rsp0_valid,
  output logic [WIDTH-1:0]       rsp0_rdata,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [AW-1:0]          req1_addr,
  input  logic [WIDTH-1:0]       req1_wdata,
  output logic                   rsp1_valid,
  output logic [WIDTH-1:0]       rsp1_rdata,
  output logic                   init_done,
  output logic [WIDTH*DEPTH-1:0] mem_flat
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] rd0_q, rd0_d;
  logic [WIDTH-1:0] rd1_q, rd1_d;

  logic             g0, g1;
  logic [AW-1:0]    sel_addr;
  logic             sel_we;
  logic [WIDTH-1:0] sel_wdata;
  logic [WIDTH-1:0] word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    done_d    = done_q;
    mem_d     = mem_q;
    v0_d      = 1'b0;
    v1_d      = 1'b0;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    g0        = 1'b0;
    g1        = 1'b0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    word      = '0;
    unique case (state_q)
      S_INIT: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_q == AW'(i)) mem_d[i] = WIDTH'(cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        g0 = req0_valid && (!req1_valid || !rr_q);
        g1 = req1_valid && (!req0_valid || rr_q);
        sel_addr  = g1 ? req1_addr  : req0_addr;
        sel_we    = g1 ? req1_we    : req0_we;
        sel_wdata = g1 ? req1_wdata : req0_wdata;
        // Out-of-range addresses match no word: reads give 0, writes vanish
        for (int i = 0; i < DEPTH; i++) begin
          if (sel_addr == AW'(i)) begin
            word = mem_q[i];
            if ((g0 || g1) && sel_we) mem_d[i] = sel_wdata;
          end
        end
        if (g0 || g1) rr_d = g0;
        if (g0 && !sel_we) begin
          v0_d  = 1'b1;
          rd0_d = word;
        end
        if (g1 && !sel_we) begin
          v1_d  = 1'b1;
          rd1_d = word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      done_q  <= 1'b0;
      mem_q   <= '{default: '0};
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rsp0_valid = v0_q;
  assign rsp1_valid = v1_q;
  assign rsp0_rdata = rd0_q;
  assign rsp1_rdata = rd1_q;
  assign init_done  = done_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
  end

endmodule
